edge_event_ctrl: RTL and testbench

// - Multi-channel successor to the single-bit edge detector.
// - Per channel: synchroniser chain, then a glitch/debounce filter, then rise/fall detection.
// - Per-channel mode selects which edges raise a sticky pending flag; pending flags are cleared by a clear vector.
// - Sits between asynchronous/noisy pins (buttons, ext. strobes) and a control FSM or interrupt line.

---
 rtl/edge_event_ctrl_if.sv | 23 ++
 rtl/edge_event_ctrl.sv | 91 +++++++++
 tb/tb_edge_event_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_ctrl_if.sv
// Channel bus for edge_event_ctrl: raw inputs and controls in, filtered levels, pulses and flags out.
interface edge_event_ctrl_if #(
    parameter int CH = 8
);
    logic [CH-1:0]   in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   level;
    logic [CH-1:0]   rise;
    logic [CH-1:0]   fall;
    logic [CH-1:0]   pending;
    logic            irq;

    modport master (
        output in, mode, clr,
        input  level, rise, fall, pending, irq
    );

    modport slave (
        input  in, mode, clr,
        output level, rise, fall, pending, irq
    );
endinterface

// File: rtl/edge_event_ctrl.sv
// Multi-channel edge event controller: per channel synchroniser, debounce filter,
// rise/fall detection and sticky pending flags selected by a per-channel mode.
module edge_event_ctrl #(
    parameter int CH       = 8,
    parameter int SYNC_STG = 2,
    parameter int FILT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    edge_event_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    generate
        if (CH < 1 || SYNC_STG < 1 || FILT_LEN < 1) begin : g_bad_param
            $fatal(1, "edge_event_ctrl: CH, SYNC_STG and FILT_LEN must all be >= 1");
        end
    endgenerate

    logic [SYNC_STG-1:0][CH-1:0] sync_q, sync_d;
    logic [CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [CH-1:0]               level_q, level_d;
    logic [CH-1:0]               rise_q, rise_d;
    logic [CH-1:0]               fall_q, fall_d;
    logic [CH-1:0]               pending_q, pending_d;
    logic [CH-1:0]               sync_c;
    logic [CH-1:0]               evt_c;

    // Synchroniser shift chain; only the last stage feeds logic.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.in;
        for (int s = 1; s < SYNC_STG; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_c = sync_q[SYNC_STG-1];

    // Debounce: a new level must differ from the current one for FILT_LEN straight cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < CH; i++) begin
            if (sync_c[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync_c[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edges come from the next-state level so pending updates in the same edge as the pulse.
    always_comb begin
        rise_d    = level_d & ~level_q;
        fall_d    = ~level_d & level_q;
        evt_c     = '0;
        for (int i = 0; i < CH; i++) begin
            evt_c[i] = (rise_d[i] & bus.mode[2*i]) | (fall_d[i] & bus.mode[2*i+1]);
        end
        pending_d = (pending_q & ~bus.clr) | evt_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            pending_q <= '0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
        end
    end

    assign bus.level   = level_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.pending = pending_q;
    assign bus.irq     = |pending_q;
endmodule

// File: tb/tb_edge_event_ctrl.sv
// Bench for edge_event_ctrl: default-parameter instance plus an unfiltered single-channel instance.
module tb_edge_event_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    edge_event_ctrl_if #(.CH(8)) bus_a ();
    edge_event_ctrl_if #(.CH(1)) bus_b ();

    edge_event_ctrl #(.CH(8), .SYNC_STG(2), .FILT_LEN(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    edge_event_ctrl #(.CH(1), .SYNC_STG(1), .FILT_LEN(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: history of sampled inputs per model, newest at index 0.
    logic [7:0] ih [2][32];
    logic [7:0] m_lvl  [2];
    logic [7:0] m_pend [2];
    logic [7:0] m_rise [2];
    logic [7:0] m_fall [2];

    typedef struct packed {
        logic       rst;
        logic [7:0] in;
        logic [7:0] e_level;
        logic [7:0] e_rise;
        logic [7:0] e_pend;
        logic       e_irq;
    } vec_t;

    vec_t tv [9];

    int         rt, ft, pr, pf;
    logic [7:0] seen;
    logic [7:0] msk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // A level flips once the last flen synchronised samples all disagree with it.
    task automatic model_step(input int id, input int sstg, input int flen, input logic r,
                              input logic [7:0] in_v, input logic [15:0] mode_v,
                              input logic [7:0] clr_v);
        logic [7:0] nl;
        logic [7:0] evt;
        bit         diff;
        if (r) begin
            for (int k = 0; k < 32; k++) ih[id][k] = '0;
            m_lvl[id]  = '0;
            m_pend[id] = '0;
            m_rise[id] = '0;
            m_fall[id] = '0;
        end else begin
            nl = m_lvl[id];
            for (int c = 0; c < 8; c++) begin
                diff = 1'b1;
                for (int j = 0; j < flen; j++) begin
                    if (ih[id][sstg-1+j][c] == m_lvl[id][c]) diff = 1'b0;
                end
                if (diff) nl[c] = ~m_lvl[id][c];
            end
            m_rise[id] = nl & ~m_lvl[id];
            m_fall[id] = ~nl & m_lvl[id];
            for (int c = 0; c < 8; c++) begin
                evt[c] = (m_rise[id][c] & mode_v[2*c]) | (m_fall[id][c] & mode_v[2*c+1]);
            end
            m_pend[id] = (m_pend[id] & ~clr_v) | evt;
            m_lvl[id]  = nl;
            for (int k = 31; k > 0; k--) ih[id][k] = ih[id][k-1];
            ih[id][0] = in_v;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 2, 4, rst, bus_a.in, bus_a.mode, bus_a.clr);
        model_step(1, 1, 1, rst, {7'b0, bus_b.in}, {14'b0, bus_b.mode}, {7'b0, bus_b.clr});
        #1;
        cyc++;
        check("a_level", bus_a.level, m_lvl[0]);
        check("a_rise", bus_a.rise, m_rise[0]);
        check("a_fall", bus_a.fall, m_fall[0]);
        check("a_pending", bus_a.pending, m_pend[0]);
        check("a_irq", 8'(bus_a.irq), 8'(|m_pend[0]));
        check("a_rise_fall_excl", bus_a.rise & bus_a.fall, 8'h00);
        check("b_level", 8'(bus_b.level), m_lvl[1]);
        check("b_rise", 8'(bus_b.rise), m_rise[1]);
        check("b_fall", 8'(bus_b.fall), m_fall[1]);
        check("b_pending", 8'(bus_b.pending), m_pend[1]);
        check("b_irq", 8'(bus_b.irq), 8'(m_pend[1][0]));
        bus_b.in   = 1'($urandom_range(0, 1));
        bus_b.mode = 2'($urandom_range(0, 3));
        bus_b.clr  = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        rst        = 1'b1;
        bus_a.in   = '0;
        bus_a.mode = 16'h5555;
        bus_a.clr  = '0;
        bus_b.in   = '0;
        bus_b.mode = '0;
        bus_b.clr  = '0;
        for (int id = 0; id < 2; id++) begin
            for (int k = 0; k < 32; k++) ih[id][k] = '0;
            m_lvl[id]  = '0;
            m_pend[id] = '0;
            m_rise[id] = '0;
            m_fall[id] = '0;
        end

        // Reset, then ch0 rises and must appear exactly 6 edges later.
        tv[0] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[1] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[2] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[3] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[4] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[5] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[6] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        tv[7] = '{1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1};
        tv[8] = '{1'b0, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1};
        for (int i = 0; i < 9; i++) begin
            rst      = tv[i].rst;
            bus_a.in = tv[i].in;
            tick();
            check("tbl_level", bus_a.level, tv[i].e_level);
            check("tbl_rise", bus_a.rise, tv[i].e_rise);
            check("tbl_pending", bus_a.pending, tv[i].e_pend);
            check("tbl_irq", 8'(bus_a.irq), 8'(tv[i].e_irq));
        end

        // 3-cycle glitch on ch3 is rejected.
        seen = '0;
        for (int t = 1; t <= 11; t++) begin
            bus_a.in[3] = (t <= 3);
            tick();
            seen[0] = seen[0] | bus_a.level[3] | bus_a.rise[3] | bus_a.pending[3];
        end
        check("glitch_reject", seen, 8'h00);

        // 4-cycle pulse on ch3 is accepted.
        rt = -1;
        ft = -1;
        for (int t = 1; t <= 14; t++) begin
            bus_a.in[3] = (t <= 4);
            tick();
            if (bus_a.rise[3] && rt < 0) rt = t;
            if (bus_a.fall[3] && ft < 0) ft = t;
        end
        check_int("pulse4_rise_edge", rt, 6);
        check_int("pulse4_fall_edge", ft, 10);

        // Mode matrix on ch1 with a 10-cycle pulse.
        for (int m = 0; m < 4; m++) begin
            bus_a.mode[3:2] = 2'(m);
            bus_a.clr[1]    = 1'b1;
            tick();
            bus_a.clr[1] = 1'b0;
            rt = -1; ft = -1; pr = -1; pf = -1;
            for (int t = 1; t <= 20; t++) begin
                bus_a.in[1]  = (t <= 10);
                bus_a.clr[1] = (m == 3 && t == 8);
                tick();
                if (bus_a.rise[1]) begin rt = t; pr = int'(bus_a.pending[1]); end
                if (bus_a.fall[1]) begin ft = t; pf = int'(bus_a.pending[1]); end
                if (m == 3 && t == 8) check_int("mode11_clr_between", int'(bus_a.pending[1]), 0);
            end
            bus_a.clr[1] = 1'b0;
            check_int("mode_rise_edge", rt, 6);
            check_int("mode_fall_edge", ft, 16);
            check_int("mode_pend_at_rise", pr, m & 1);
            check_int("mode_pend_at_fall", pf, (m != 0) ? 1 : 0);
        end

        // Clear colliding with a set on ch2: set wins, next clear empties irq.
        bus_a.clr = 8'hff;
        tick();
        bus_a.clr = 8'h00;
        for (int t = 1; t <= 7; t++) begin
            bus_a.in[2]  = 1'b1;
            bus_a.clr[2] = (t >= 6);
            tick();
            if (t == 6) begin
                check("collide_rise", 8'(bus_a.rise[2]), 8'h01);
                check("collide_pend_kept", 8'(bus_a.pending[2]), 8'h01);
            end
            if (t == 7) begin
                check("late_clr_pend", 8'(bus_a.pending[2]), 8'h00);
                check("late_clr_irq", 8'(bus_a.irq), 8'h00);
            end
        end
        bus_a.clr = 8'h00;

        // Reset mid-filter on ch5 with its pending flag set.
        bus_a.in[5] = 1'b1;
        for (int t = 0; t < 8; t++) tick();
        check("ch5_pend_set", 8'(bus_a.pending[5]), 8'h01);
        bus_a.in[5] = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        bus_a.in[5] = 1'b1;
        for (int t = 0; t < 4; t++) tick();
        check("ch5_mid_filter_level", 8'(bus_a.level[5]), 8'h00);
        check("ch5_mid_filter_pend", 8'(bus_a.pending[5]), 8'h01);
        rst = 1'b1;
        tick();
        check("rst_level", bus_a.level, 8'h00);
        check("rst_rise", bus_a.rise, 8'h00);
        check("rst_fall", bus_a.fall, 8'h00);
        check("rst_pending", bus_a.pending, 8'h00);
        check("rst_irq", 8'(bus_a.irq), 8'h00);
        rst = 1'b0;
        rt  = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (bus_a.rise[5] && rt < 0) rt = t;
        end
        check_int("post_rst_rise_edge", rt, 6);

        // Randomised traffic on both instances against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 8; c++) msk[c] = ($urandom_range(0, 7) == 0);
            bus_a.in ^= msk;
            for (int c = 0; c < 8; c++) msk[c] = ($urandom_range(0, 7) == 0);
            bus_a.clr = msk;
            if ((n % 64) == 0) bus_a.mode = 16'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
